// File: rtl/n101_qspi_pkg.sv
// Shared widths and arbiter state encoding for the n101 QSPI blocks.
package n101_qspi_pkg;

    localparam int QSPI_TX_W    = 8;
    localparam int QSPI_CNT_W   = 8;
    localparam int QSPI_PROTO_W = 2;

    typedef enum logic {
        ARB_OWN    = 1'b0,
        ARB_SWITCH = 1'b1
    } arb_state_t;

endpackage

// File: rtl/n101_qspi_rr_pick.sv
// Rotate-priority picker: finds the first requester after the current owner,
// wrapping modulo N. The owner itself is never reported as found.
module n101_qspi_rr_pick #(
    parameter int N    = 2,
    parameter int SELW = 3
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] owner,
    output logic            found,
    output logic [SELW-1:0] index
);

    int pos;

    // Walk from the farthest ring position back to owner+1 so the nearest requester wins
    always_comb begin
        found = 1'b0;
        index = owner;
        pos   = 0;
        for (int k = N - 1; k >= 1; k--) begin
            pos = int'(owner) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            for (int j = 0; j < N; j++) begin
                if ((j == pos) && req[j]) begin
                    found = 1'b1;
                    index = SELW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/n101_qspi_arbiter_nch.sv
// N-channel QSPI arbiter: muxes one of N inner frontends onto the outer
// serialiser, with software-select or round-robin ownership and a one-cycle
// SWITCH state that drains the link and pulses cs_clear between owners.
module n101_qspi_arbiter_nch
    import n101_qspi_pkg::*;
#(
    parameter int N            = 2,
    parameter int SELW         = 3,
    parameter int LOCK_TIMEOUT = 0
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      io_mode,
    input  logic [SELW-1:0]           io_sel,
    input  logic [N-1:0]              io_inner_tx_valid,
    input  logic [QSPI_TX_W*N-1:0]    io_inner_tx_bits,
    input  logic [QSPI_CNT_W*N-1:0]   io_inner_cnt,
    input  logic [QSPI_PROTO_W*N-1:0] io_inner_fmt_proto,
    input  logic [N-1:0]              io_inner_fmt_endian,
    input  logic [N-1:0]              io_inner_fmt_iodir,
    input  logic [N-1:0]              io_inner_cs_set,
    input  logic [N-1:0]              io_inner_cs_clear,
    input  logic [N-1:0]              io_inner_cs_hold,
    input  logic [N-1:0]              io_inner_lock,
    output logic [N-1:0]              io_inner_tx_ready,
    output logic [N-1:0]              io_inner_rx_valid,
    output logic [QSPI_TX_W-1:0]      io_inner_rx_bits,
    output logic [N-1:0]              io_inner_active,
    input  logic                      io_outer_tx_ready,
    output logic                      io_outer_tx_valid,
    output logic [QSPI_TX_W-1:0]      io_outer_tx_bits,
    input  logic                      io_outer_rx_valid,
    input  logic [QSPI_TX_W-1:0]      io_outer_rx_bits,
    output logic [QSPI_CNT_W-1:0]     io_outer_cnt,
    output logic [QSPI_PROTO_W-1:0]   io_outer_fmt_proto,
    output logic                      io_outer_fmt_endian,
    output logic                      io_outer_fmt_iodir,
    output logic                      io_outer_cs_set,
    output logic                      io_outer_cs_clear,
    output logic                      io_outer_cs_hold,
    input  logic                      io_outer_active,
    output logic [SELW-1:0]           io_owner,
    output logic                      io_switching
);

    arb_state_t            state, state_nxt;
    logic [SELW-1:0]       owner, owner_nxt;
    logic [SELW-1:0]       pend, pend_nxt;
    logic [SELW-1:0]       cand;
    logic [SELW-1:0]       pick_index;
    logic                  pick_found;
    logic [N-1:0]          sel;
    logic                  lock;
    logic                  expired;
    logic                  switch_go;
    logic                  in_switch;

    logic                    mux_tx_valid;
    logic [QSPI_TX_W-1:0]    mux_tx_bits;
    logic [QSPI_CNT_W-1:0]   mux_cnt;
    logic [QSPI_PROTO_W-1:0] mux_proto;
    logic                    mux_endian;
    logic                    mux_iodir;
    logic                    mux_cs_set;
    logic                    mux_cs_clear;
    logic                    mux_cs_hold;

    n101_qspi_rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_pick (
        .req   (io_inner_tx_valid),
        .owner (owner),
        .found (pick_found),
        .index (pick_index)
    );

    // Expand the owner index into a one-hot channel select
    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) begin
            sel[i] = (owner == SELW'(i));
        end
    end

    // AND-OR mux of the selected channel's fields onto the outer link
    always_comb begin
        mux_tx_valid = 1'b0;
        mux_tx_bits  = '0;
        mux_cnt      = '0;
        mux_proto    = '0;
        mux_endian   = 1'b0;
        mux_iodir    = 1'b0;
        mux_cs_set   = 1'b0;
        mux_cs_clear = 1'b0;
        mux_cs_hold  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel[i]) begin
                mux_tx_valid = mux_tx_valid | io_inner_tx_valid[i];
                mux_tx_bits  = mux_tx_bits  | io_inner_tx_bits[QSPI_TX_W*i +: QSPI_TX_W];
                mux_cnt      = mux_cnt      | io_inner_cnt[QSPI_CNT_W*i +: QSPI_CNT_W];
                mux_proto    = mux_proto    | io_inner_fmt_proto[QSPI_PROTO_W*i +: QSPI_PROTO_W];
                mux_endian   = mux_endian   | io_inner_fmt_endian[i];
                mux_iodir    = mux_iodir    | io_inner_fmt_iodir[i];
                mux_cs_set   = mux_cs_set   | io_inner_cs_set[i];
                mux_cs_clear = mux_cs_clear | io_inner_cs_clear[i];
                mux_cs_hold  = mux_cs_hold  | io_inner_cs_hold[i];
            end
        end
    end

    assign in_switch = (state == ARB_SWITCH);
    assign lock      = |(sel & io_inner_lock);

    // During SWITCH the link is drained: no tx, chip select forced to clear
    assign io_outer_tx_valid   = mux_tx_valid & ~in_switch;
    assign io_outer_tx_bits    = mux_tx_bits;
    assign io_outer_cnt        = mux_cnt;
    assign io_outer_fmt_proto  = mux_proto;
    assign io_outer_fmt_endian = mux_endian;
    assign io_outer_fmt_iodir  = mux_iodir;
    assign io_outer_cs_set     = mux_cs_set & ~in_switch;
    assign io_outer_cs_clear   = mux_cs_clear | in_switch;
    assign io_outer_cs_hold    = mux_cs_hold & ~in_switch;

    assign io_inner_tx_ready = {N{io_outer_tx_ready & ~in_switch}} & sel;
    assign io_inner_rx_valid = {N{io_outer_rx_valid}} & sel;
    assign io_inner_active   = {N{io_outer_active}} & sel;
    assign io_inner_rx_bits  = io_outer_rx_bits;

    assign io_owner     = owner;
    assign io_switching = in_switch;

    // Candidate owner: software index (out-of-range keeps owner) or next RR requester
    always_comb begin
        cand = owner;
        if (io_mode) begin
            if (pick_found) begin
                cand = pick_index;
            end
        end else if (int'(io_sel) < N) begin
            cand = io_sel;
        end
    end

    // Owner-switch FSM next-state: leave OWN only when the link is idle and unlocked
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        pend_nxt  = pend;
        switch_go = 1'b0;
        case (state)
            ARB_OWN: begin
                if ((cand != owner) && !io_outer_active &&
                    (!lock || (io_mode && expired))) begin
                    state_nxt = ARB_SWITCH;
                    pend_nxt  = cand;
                    switch_go = 1'b1;
                end
            end
            ARB_SWITCH: begin
                state_nxt = ARB_OWN;
                owner_nxt = pend;
            end
            default: begin
                state_nxt = ARB_OWN;
            end
        endcase
    end

    // FSM state, owner and pending-owner registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARB_OWN;
            owner <= '0;
            pend  <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            pend  <= pend_nxt;
        end
    end

    if (LOCK_TIMEOUT > 0) begin : g_timeout
        localparam logic [15:0] TO_LIMIT = 16'(LOCK_TIMEOUT);
        logic [15:0] to_cnt;
        logic        other_req;

        assign other_req = |(io_inner_tx_valid & ~sel);
        assign expired   = (to_cnt == TO_LIMIT);

        // Saturating starvation counter, cleared whenever the starvation condition lapses
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                to_cnt <= '0;
            end else if ((state == ARB_OWN) && !switch_go && io_mode && lock && other_req) begin
                if (to_cnt != TO_LIMIT) begin
                    to_cnt <= to_cnt + 16'd1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end else begin : g_no_timeout
        assign expired = 1'b0;
    end

endmodule

// File: tb/tb_n101_qspi_arbiter_nch.sv
// Scoreboard bench for the N-channel QSPI arbiter (N = 4). A second instance
// without lock timeout shares all inputs to show a locked owner is never forced out.
module tb_n101_qspi_arbiter_nch;

    localparam int N    = 4;
    localparam int SELW = 3;

    typedef enum int {
        K_OWNER, K_SWITCH, K_CSCLR, K_CSSET, K_TXBITS, K_CNT, K_TXRDY, K_TXVAL, K_OWNER_NT
    } kind_t;

    typedef struct {
        int          due;
        kind_t       kind;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    logic            clock;
    logic            reset_n;
    logic            io_mode;
    logic [SELW-1:0] io_sel;
    logic [N-1:0]    tx_valid;
    logic [8*N-1:0]  tx_bits;
    logic [8*N-1:0]  cnt;
    logic [2*N-1:0]  proto;
    logic [N-1:0]    endian;
    logic [N-1:0]    iodir;
    logic [N-1:0]    cs_set;
    logic [N-1:0]    cs_clear;
    logic [N-1:0]    cs_hold;
    logic [N-1:0]    lock;
    logic            outer_tx_ready;
    logic            outer_rx_valid;
    logic [7:0]      outer_rx_bits;
    logic            outer_active;

    logic [N-1:0]    tx_ready, rx_valid, active;
    logic [7:0]      rx_bits;
    logic            o_tx_valid, o_endian, o_iodir, o_cs_set, o_cs_clear, o_cs_hold;
    logic [7:0]      o_tx_bits, o_cnt;
    logic [1:0]      o_proto;
    logic [SELW-1:0] io_owner;
    logic            io_switching;

    logic [N-1:0]    nt_tx_ready, nt_rx_valid, nt_active;
    logic [7:0]      nt_rx_bits;
    logic            nt_tx_valid, nt_endian, nt_iodir, nt_cs_set, nt_cs_clear, nt_cs_hold;
    logic [7:0]      nt_tx_bits, nt_cnt;
    logic [1:0]      nt_proto;
    logic [SELW-1:0] nt_owner;
    logic            nt_switching;

    exp_t sb[$];
    int   cyc;
    int   vec_count;
    int   miscompares;

    n101_qspi_arbiter_nch #(.N(N), .SELW(SELW), .LOCK_TIMEOUT(8)) dut (
        .clock(clock), .reset_n(reset_n), .io_mode(io_mode), .io_sel(io_sel),
        .io_inner_tx_valid(tx_valid), .io_inner_tx_bits(tx_bits), .io_inner_cnt(cnt),
        .io_inner_fmt_proto(proto), .io_inner_fmt_endian(endian), .io_inner_fmt_iodir(iodir),
        .io_inner_cs_set(cs_set), .io_inner_cs_clear(cs_clear), .io_inner_cs_hold(cs_hold),
        .io_inner_lock(lock), .io_inner_tx_ready(tx_ready), .io_inner_rx_valid(rx_valid),
        .io_inner_rx_bits(rx_bits), .io_inner_active(active),
        .io_outer_tx_ready(outer_tx_ready), .io_outer_tx_valid(o_tx_valid),
        .io_outer_tx_bits(o_tx_bits), .io_outer_rx_valid(outer_rx_valid),
        .io_outer_rx_bits(outer_rx_bits), .io_outer_cnt(o_cnt), .io_outer_fmt_proto(o_proto),
        .io_outer_fmt_endian(o_endian), .io_outer_fmt_iodir(o_iodir),
        .io_outer_cs_set(o_cs_set), .io_outer_cs_clear(o_cs_clear), .io_outer_cs_hold(o_cs_hold),
        .io_outer_active(outer_active), .io_owner(io_owner), .io_switching(io_switching)
    );

    n101_qspi_arbiter_nch #(.N(N), .SELW(SELW), .LOCK_TIMEOUT(0)) dut_nt (
        .clock(clock), .reset_n(reset_n), .io_mode(io_mode), .io_sel(io_sel),
        .io_inner_tx_valid(tx_valid), .io_inner_tx_bits(tx_bits), .io_inner_cnt(cnt),
        .io_inner_fmt_proto(proto), .io_inner_fmt_endian(endian), .io_inner_fmt_iodir(iodir),
        .io_inner_cs_set(cs_set), .io_inner_cs_clear(cs_clear), .io_inner_cs_hold(cs_hold),
        .io_inner_lock(lock), .io_inner_tx_ready(nt_tx_ready), .io_inner_rx_valid(nt_rx_valid),
        .io_inner_rx_bits(nt_rx_bits), .io_inner_active(nt_active),
        .io_outer_tx_ready(outer_tx_ready), .io_outer_tx_valid(nt_tx_valid),
        .io_outer_tx_bits(nt_tx_bits), .io_outer_rx_valid(outer_rx_valid),
        .io_outer_rx_bits(outer_rx_bits), .io_outer_cnt(nt_cnt), .io_outer_fmt_proto(nt_proto),
        .io_outer_fmt_endian(nt_endian), .io_outer_fmt_iodir(nt_iodir),
        .io_outer_cs_set(nt_cs_set), .io_outer_cs_clear(nt_cs_clear), .io_outer_cs_hold(nt_cs_hold),
        .io_outer_active(outer_active), .io_owner(nt_owner), .io_switching(nt_switching)
    );

    // Free-running clock, period 10
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] observe(kind_t k);
        case (k)
            K_OWNER:    return 32'(io_owner);
            K_SWITCH:   return 32'(io_switching);
            K_CSCLR:    return 32'(o_cs_clear);
            K_CSSET:    return 32'(o_cs_set);
            K_TXBITS:   return 32'(o_tx_bits);
            K_CNT:      return 32'(o_cnt);
            K_TXRDY:    return 32'(tx_ready);
            K_TXVAL:    return 32'(o_tx_valid);
            K_OWNER_NT: return 32'(nt_owner);
            default:    return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expectOut(input int lat, input kind_t k, input logic [31:0] v, input string tag);
        exp_t e;
        e.due  = cyc + lat;
        e.kind = k;
        e.exp  = v;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic m, input logic [SELW-1:0] s,
                                 input logic [N-1:0] v, input logic [N-1:0] l);
        io_mode  = m;
        io_sel   = s;
        tx_valid = v;
        lock     = l;
    endtask

    // Compare everything due this cycle at the falling edge, then move to just past the next rising edge
    task automatic tick();
        int i;
        @(negedge clock);
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due == cyc) begin
                checkOutput(sb[i].tag, observe(sb[i].kind), sb[i].exp);
                sb.delete(i);
            end else begin
                i++;
            end
        end
        cyc++;
        @(posedge clock);
        #1;
    endtask

    initial begin
        cyc         = 0;
        vec_count   = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        tx_bits     = {8'h33, 8'h22, 8'h11, 8'hA5};
        cnt         = {8'h18, 8'h10, 8'h08, 8'h04};
        proto       = '0;
        endian      = '0;
        iodir       = '0;
        cs_set      = '1;
        cs_clear    = '0;
        cs_hold     = '0;
        outer_tx_ready = 1'b1;
        outer_rx_valid = 1'b0;
        outer_rx_bits  = 8'h00;
        outer_active   = 1'b0;
        applyStimulus(1'b0, 3'd0, 4'b1111, 4'b0000);

        // Reset state
        expectOut(0, K_OWNER, 0, "rst_owner");
        expectOut(0, K_SWITCH, 0, "rst_switching");
        expectOut(0, K_TXBITS, 32'hA5, "rst_tx_bits");
        tick();
        reset_n = 1'b1;
        expectOut(0, K_OWNER, 0, "rel_owner");
        expectOut(0, K_SWITCH, 0, "rel_switching");
        expectOut(0, K_TXBITS, 32'hA5, "rel_tx_bits");
        expectOut(0, K_CNT, 32'h04, "rel_cnt");
        expectOut(0, K_TXRDY, 32'h1, "rel_tx_ready");
        tick();
        tick();

        // Software-select switch to channel 2
        applyStimulus(1'b0, 3'd2, 4'b1111, 4'b0000);
        expectOut(0, K_OWNER, 0, "m0_owner_k");
        expectOut(0, K_TXVAL, 1, "m0_txval_k");
        expectOut(1, K_SWITCH, 1, "m0_switching");
        expectOut(1, K_CSCLR, 1, "m0_cs_clear");
        expectOut(1, K_CSSET, 0, "m0_cs_set_forced");
        expectOut(1, K_TXVAL, 0, "m0_txval_forced");
        expectOut(1, K_TXRDY, 0, "m0_txrdy_forced");
        expectOut(1, K_OWNER, 0, "m0_owner_sw");
        expectOut(2, K_OWNER, 2, "m0_owner_new");
        expectOut(2, K_SWITCH, 0, "m0_switch_done");
        expectOut(2, K_CNT, 32'h10, "m0_cnt_ch2");
        expectOut(2, K_TXBITS, 32'h22, "m0_txbits_ch2");
        expectOut(2, K_TXRDY, 32'h4, "m0_txrdy_ch2");
        expectOut(2, K_CSCLR, 0, "m0_cs_clear_done");
        expectOut(2, K_CSSET, 1, "m0_cs_set_back");
        repeat (3) tick();

        // Back to channel 0, then a lock on channel 0 holds the bus
        applyStimulus(1'b0, 3'd0, 4'b1111, 4'b0000);
        expectOut(2, K_OWNER, 0, "back_to_0");
        repeat (3) tick();
        for (int t = 0; t < 20; t++) begin
            applyStimulus(1'b0, 3'd1, 4'b1111, 4'b0001);
            expectOut(0, K_OWNER, 0, "lock_owner_held");
            expectOut(0, K_SWITCH, 0, "lock_no_switch");
            tick();
        end
        applyStimulus(1'b0, 3'd1, 4'b1111, 4'b0000);
        expectOut(0, K_OWNER, 0, "unlock_owner_k");
        expectOut(1, K_SWITCH, 1, "unlock_switching");
        expectOut(2, K_OWNER, 1, "unlock_owner_new");
        repeat (3) tick();

        // Out-of-range software select keeps the current owner
        for (int t = 0; t < 4; t++) begin
            applyStimulus(1'b0, 3'd7, 4'b1111, 4'b0000);
            expectOut(0, K_OWNER, 1, "sel7_owner");
            expectOut(0, K_SWITCH, 0, "sel7_no_switch");
            tick();
        end

        // Round-robin from owner 0 with channels 0,1,3 requesting
        applyStimulus(1'b0, 3'd0, 4'b1111, 4'b0000);
        expectOut(2, K_OWNER, 0, "rr_prep_owner");
        repeat (3) tick();
        applyStimulus(1'b1, 3'd0, 4'b1011, 4'b0000);
        expectOut(0, K_OWNER, 0, "rr_owner_start");
        expectOut(1, K_SWITCH, 1, "rr_sw1");
        expectOut(2, K_OWNER, 1, "rr_owner_1");
        expectOut(2, K_SWITCH, 0, "rr_own1");
        expectOut(3, K_SWITCH, 1, "rr_sw2");
        expectOut(4, K_OWNER, 3, "rr_owner_3");
        expectOut(5, K_SWITCH, 1, "rr_sw3");
        expectOut(6, K_OWNER, 0, "rr_owner_0");
        expectOut(7, K_SWITCH, 1, "rr_sw4");
        expectOut(8, K_OWNER, 1, "rr_owner_1b");
        repeat (9) tick();
        applyStimulus(1'b1, 3'd0, 4'b0000, 4'b0000);
        expectOut(0, K_SWITCH, 1, "rr_sw5");
        expectOut(1, K_OWNER, 3, "rr_owner_3b");
        expectOut(3, K_OWNER, 3, "rr_idle_hold");
        expectOut(3, K_SWITCH, 0, "rr_idle_no_switch");
        repeat (4) tick();

        // Lock timeout: channel 0 locked owner, channel 1 starved
        applyStimulus(1'b1, 3'd0, 4'b0001, 4'b0001);
        expectOut(2, K_OWNER, 0, "to_prep_owner");
        expectOut(2, K_OWNER_NT, 0, "to_prep_owner_nt");
        repeat (3) tick();
        applyStimulus(1'b1, 3'd0, 4'b0010, 4'b0001);
        expectOut(8, K_OWNER, 0, "to_owner_held");
        expectOut(8, K_SWITCH, 0, "to_not_early");
        expectOut(9, K_SWITCH, 1, "to_forced_switch");
        expectOut(10, K_OWNER, 1, "to_owner_new");
        expectOut(10, K_OWNER_NT, 0, "nt_owner_held");
        expectOut(14, K_OWNER_NT, 0, "nt_owner_held_late");
        repeat (15) tick();

        // Reset asserted in the middle of a SWITCH cycle
        applyStimulus(1'b0, 3'd2, 4'b1111, 4'b0000);
        tick();
        #2;
        checkOutput("rst_mid_in_switch", 32'(io_switching), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_mid_owner", 32'(io_owner), 32'd0);
        checkOutput("rst_mid_switching", 32'(io_switching), 32'd0);
        checkOutput("rst_mid_owner_nt", 32'(nt_owner), 32'd0);
        tick();
        applyStimulus(1'b0, 3'd0, 4'b1111, 4'b0000);
        reset_n = 1'b1;
        expectOut(0, K_OWNER, 0, "post_rst_owner");
        expectOut(2, K_OWNER, 0, "post_rst_pend_gone");
        expectOut(2, K_SWITCH, 0, "post_rst_no_switch");
        repeat (3) tick();

        for (int t = 0; t < 20 && sb.size() > 0; t++) begin
            tick();
        end
        if (sb.size() > 0) begin
            checkOutput("sb_drain", 32'(sb.size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
